// File: rtl/jzjpcc_mmio_uart_tx_if.sv
// ----------------------------------------------------------------------------
// jzjpcc_mmio_uart_tx_if
// Purpose : MMIO word pair between the JZJ core and the UART transmitter.
// Signals : mmioCommand [31:0] - core output word (data, clear toggle, write toggle)
//           mmioStatus  [31:0] - core input word (acks, overflow, busy, full, fill count)
// Modports: master = core side (drives mmioCommand)
//           slave  = UART side (drives mmioStatus)
// ----------------------------------------------------------------------------
interface jzjpcc_mmio_uart_tx_if;
    logic [31:0] mmioCommand;
    logic [31:0] mmioStatus;

    modport master (output mmioCommand, input mmioStatus);
    modport slave  (input mmioCommand, output mmioStatus);
endinterface

// File: rtl/jzjpcc_mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// jzjpcc_mmio_uart_tx
// Purpose : MMIO-side UART transmitter (8N1). Software pushes bytes with a
//           toggle handshake; bytes are buffered in a circular FIFO and
//           serialised LSB first on txd.
// Ports   : clock - single clock, same domain as the core
//           reset - asynchronous assert, active low
//           mmio  - slave side of the command/status word pair
//           txd   - registered UART serial output, idle high
// Status  : [31] write-ack toggle, [30] clear-ack toggle, [29] sticky overflow,
//           [28] busy, [27] FIFO full, [15:0] FIFO fill count
// ----------------------------------------------------------------------------
module jzjpcc_mmio_uart_tx #(
    parameter int BAUD_DIVISOR    = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    jzjpcc_mmio_uart_tx_if.slave        mmio,
    output logic                        txd
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int BW    = $clog2(BAUD_DIVISOR);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIVISOR - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              count_q, count_d;
    logic                       last_wr_q, last_clr_q;
    logic                       ack_wr_q, ack_clr_q;
    logic                       ovf_q, ovf_d;
    logic                       busy_q, full_q;

    state_t                     state_q;
    logic [7:0]                 shift_q;
    logic [BW-1:0]              baud_q;
    logic [2:0]                 bit_q;
    logic                       txd_q;

    logic wr_req, clr_req, push, pop, baud_zero, fsm_idle_d;
    logic unused_cmd;

    assign unused_cmd = ^mmio.mmioCommand[29:8];

    always_comb begin
        wr_req    = mmio.mmioCommand[31] != last_wr_q;
        clr_req   = mmio.mmioCommand[30] != last_clr_q;
        baud_zero = (baud_q == '0);
        // The shifter takes a byte when idle, or at the very end of a stop
        // bit so consecutive frames run without an idle gap.
        pop = (count_q != '0) &&
              ((state_q == IDLE) || ((state_q == STOP) && baud_zero));
        // A full FIFO still accepts a byte when a pop frees a slot this edge.
        push = wr_req && ((count_q != DEPTH_C) || pop);

        // Overflow set wins over a clear landing on the same edge.
        ovf_d = ovf_q;
        if (clr_req)
            ovf_d = 1'b0;
        if (wr_req && !push)
            ovf_d = 1'b1;

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;

        // FSM will rest in IDLE after this edge.
        fsm_idle_d = !pop &&
                     ((state_q == IDLE) || ((state_q == STOP) && baud_zero));
    end

    // Handshake, FIFO bookkeeping and registered status bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_wr_q  <= 1'b0;
            last_clr_q <= 1'b0;
            ack_wr_q   <= 1'b0;
            ack_clr_q  <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            if (wr_req) begin
                last_wr_q <= mmio.mmioCommand[31];
                ack_wr_q  <= mmio.mmioCommand[31];
            end
            if (clr_req) begin
                last_clr_q <= mmio.mmioCommand[30];
                ack_clr_q  <= mmio.mmioCommand[30];
            end
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            busy_q  <= !fsm_idle_d || (count_d != '0);
            full_q  <= (count_d == DEPTH_C);
        end
    end

    // Storage kept free of reset so it maps onto RAM; contents are
    // meaningless once the pointers are reset.
    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= mmio.mmioCommand[7:0];
    end

    // Serialiser. txd is updated together with the state so the line value
    // always matches the bit being sent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= BAUD_RELOAD;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_zero) begin
                        baud_q  <= BAUD_RELOAD;
                        bit_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_zero) begin
                        baud_q  <= BAUD_RELOAD;
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_zero) begin
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            baud_q  <= BAUD_RELOAD;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txd = txd_q;
    assign mmio.mmioStatus = {ack_wr_q, ack_clr_q, ovf_q, busy_q, full_q,
                              11'b0, 16'(count_q)};

endmodule
